fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO write data width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant; at least 1.
REQ-004 SHALL have port clk, input, 1: single clock, the FIFO write clock; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ: requester i has a beat.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last, input, NUM_REQ: current beat of requester i ends its packet.
REQ-009 SHALL have port req_ready, output, NUM_REQ: beat of requester i accepted this cycle.
REQ-010 SHALL have port full, input, 1: FIFO full flag, write domain.
REQ-011 SHALL have port wr_en, output, 1: FIFO write enable.
REQ-012 SHALL have port wr_data, output, DATA_WIDTH: FIFO write data.
REQ-013 SHALL have port grant_id, output, clog2(NUM_REQ): index of the current grant holder; 0 when idle.
REQ-014 SHALL have port busy, output, 1: a grant is held (state GRANT).

Function
REQ-015 SHALL implement the states IDLE and GRANT.
REQ-016 In IDLE, with any req_valid high, SHALL pick the first valid requester, searching upward from rr_ptr with wrap; it SHALL register the pick as grant_id and enter GRANT on the next edge.
REQ-017 Arbitration latency SHALL be one cycle: req_valid rising in IDLE at cycle t gives the first possible transfer at t+1.
REQ-018 In GRANT: req_ready[g] = req_valid[g] & !full & !rst, where g = grant_id.
REQ-019 All other req_ready bits SHALL be 0.
REQ-020 wr_en SHALL equal req_ready[g], combinationally.
REQ-021 wr_data SHALL equal req_data slice g in GRANT and 0 otherwise.
REQ-022 A beat transfers when req_valid[g] & req_ready[g]; each transfer SHALL increment beat_cnt (width clog2(MAX_BURST)+1).
REQ-023 While full is high in GRANT, the block SHALL hold the grant with no transfer and no count.
REQ-024 Release SHALL occur on a transferring beat with req_last[g]=1, on the MAX_BURST-th transfer, or when req_valid[g]=0 in GRANT (withdrawal).
REQ-025 On release: next state IDLE, rr_ptr = (g+1) mod NUM_REQ, beat_cnt = 0.
REQ-026 Every release SHALL cost one IDLE bubble cycle; there SHALL be no GRANT-to-GRANT handover.
REQ-027 Simultaneous last beat and MAX_BURST limit SHALL cause a single release.
REQ-028 A single requester that stays valid SHALL be re-granted after the bubble.
REQ-029 The block SHALL never assert wr_en while full=1; no data SHALL be dropped or duplicated.
REQ-030 A requester SHALL hold req_data and req_last stable while req_valid=1 and req_ready=0; the arbiter SHALL not check this.

Reset
REQ-031 With rst high at an edge: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
REQ-032 While rst is high, wr_en, req_ready, busy and wr_data SHALL be 0, combinationally gated, including mid-burst.
REQ-033 After reset release, arbitration SHALL start from requester 0.

Structure
REQ-034 Shared package fifo_arb_pkg SHALL hold the default NUM_REQ/DATA_WIDTH/MAX_BURST constants and the state encoding (IDLE=0, GRANT=1).
REQ-035 The combinational round-robin picker SHALL be the sub-module rr_pick, with inputs req and ptr and outputs gnt_idx and any_req.
REQ-036 The top level SHALL contain the FSM, beat counter, rr_ptr and output muxing.

Verification
REQ-037 Round-robin: reset, then req_valid=4'b1111, all req_last=1 -> grants 0,1,2,3,0, one beat each; wr_en pattern 0,1,0,1,... (one bubble between grants).
REQ-038 Burst cap: req 2 valid, 10 beats, req_last=0, MAX_BURST=4 -> beats 0x00..0x03 written, bubble, 0x04..0x07, bubble, 0x08..0x09.
REQ-039 Full stall: req 1 granted, full=1 for 3 cycles mid-burst -> wr_en=0 and req_ready=0 for those cycles, grant_id stays 1, no count; the burst resumes with the next unwritten beat.
REQ-040 Withdrawal: req 3 granted, req_valid[3] drops after 1 beat -> IDLE next edge, rr_ptr=0, then a pending req 0 is granted.
REQ-041 Reset mid-burst: rst for 1 cycle during a req 2 burst -> wr_en=0 that cycle, busy=0 next cycle; req 2 wins next only if it is the first valid from index 0.
REQ-042 Scoreboard: random valid/last/full over 10k cycles -> FIFO input stream equals the per-requester sequences in order, with no write while full=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and FSM encoding for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic [IDX_W:0] sum;

    // Walk from the farthest offset down so the closest valid index to ptr is written last.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[sum[IDX_W-1:0]]) begin
                gnt_idx = sum[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding one FIFO write port from NUM_REQ valid/ready requesters, with burst cap.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             xfer;
    logic             release_g;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Release on withdrawal, on a last beat, or on the cap; last and cap together is still one release.
    always_comb begin
        xfer      = (state_q == GRANT) && req_valid[grant_q] && !full;
        release_g = (state_q == GRANT) &&
                    (!req_valid[grant_q] ||
                     (xfer && (req_last[grant_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1))));
        state_d   = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = GRANT;
            GRANT:   if (release_g) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE && any_req) begin
            grant_d = pick_idx;
        end else if (release_g) begin
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    // grant_q is cleared on release, so it already reads 0 while idle.
    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        busy      = 1'b0;
        grant_id  = grant_q;
        if (state_q == GRANT && !rst) begin
            busy               = 1'b1;
            req_ready[grant_q] = req_valid[grant_q] && !full;
            wr_en              = req_valid[grant_q] && !full;
            wr_data            = slice[grant_q];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter with default parameters.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            full;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q [NR][$];

    fifo_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; full = 1'b0;
        req_data = 32'hA1B2C3D4;
        @(negedge clk);
        tests_run++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0 || wr_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: wr_en=%b busy=%b ready=%b data=%h want 0/0/0/00", wr_en, busy, req_ready, wr_data);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (grant_id !== 2'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: grant_id=%0d busy=%b want 0/0", grant_id, busy);
        end
        rst = 1'b0; req_valid = '0;
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b wr_en=%b want 0/0", busy, wr_en);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        req_valid = 4'hF; req_last = 4'hF;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (wr_en !== (k % 2 == 1)) begin
                tests_failed++;
                $display("FAIL rr_wr_en cycle %0d: got %b want %b", k, wr_en, (k % 2 == 1));
            end
            if (k % 2 == 1) begin
                g = ((k - 1) / 2) % 4;
                tests_run++;
                if (grant_id !== 2'(g) || wr_data !== 8'(8'h10 + g) || req_ready !== 4'(1 << g)) begin
                    tests_failed++;
                    $display("FAIL rr_grant cycle %0d: id=%0d data=%h ready=%b want %0d/%h/%b",
                             k, grant_id, wr_data, req_ready, g, 8'(8'h10 + g), 4'(1 << g));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_burst_cap();
        bit exp_wr [15];
        int b    = 0;
        int nexp = 0;
        logic acc;
        exp_wr = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 15; c++) begin
            req_valid = (b < 10) ? 4'b0100 : 4'b0000;
            req_last  = '0;
            req_data  = {8'h00, 8'(b), 16'h0000};
            @(negedge clk);
            tests_run++;
            if (wr_en !== exp_wr[c]) begin
                tests_failed++;
                $display("FAIL burst_wr_en cycle %0d: got %b want %b", c, wr_en, exp_wr[c]);
            end
            if (exp_wr[c]) begin
                tests_run++;
                if (wr_data !== 8'(nexp) || grant_id !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL burst_data cycle %0d: data=%h id=%0d want %h/2", c, wr_data, grant_id, 8'(nexp));
                end
                nexp++;
            end
            acc = req_ready[2];
            next_cycle();
            if (acc) b++;
        end
        tests_run++;
        if (b !== 10 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_total: beats=%0d busy=%b want 10/0", b, busy);
        end
    endtask

    task automatic test_full_stall();
        bit exp_wr [10];
        bit exp_busy [10];
        int b = 0;
        logic acc;
        exp_wr   = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0};
        exp_busy = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_valid = (b < 4) ? 4'b0010 : 4'b0000;
            req_last  = {2'b00, (b == 3), 1'b0};
            req_data  = {16'h0000, 8'(8'h20 + b), 8'h00};
            full      = (c >= 2 && c <= 4);
            @(negedge clk);
            tests_run++;
            if (wr_en !== exp_wr[c] || busy !== exp_busy[c] || req_ready !== {2'b00, exp_wr[c], 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_ctrl cycle %0d: wr_en=%b busy=%b ready=%b want %b/%b", c, wr_en, busy, req_ready, exp_wr[c], exp_busy[c]);
            end
            if (exp_busy[c]) begin
                tests_run++;
                if (grant_id !== 2'd1 || (exp_wr[c] && wr_data !== 8'(8'h20 + b))) begin
                    tests_failed++;
                    $display("FAIL stall_grant cycle %0d: id=%0d data=%h want 1/%h", c, grant_id, wr_data, 8'(8'h20 + b));
                end
            end
            acc = req_ready[1];
            next_cycle();
            if (acc) b++;
        end
        full = 1'b0;
    endtask

    task automatic test_withdrawal();
        do_reset();
        req_valid = 4'b1000; req_last = '0; req_data = {8'h33, 8'h00, 8'h41, 8'h40};
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (wr_en !== 1'b1 || grant_id !== 2'd3 || wr_data !== 8'h33) begin
            tests_failed++;
            $display("FAIL wd_first: wr_en=%b id=%0d data=%h want 1/3/33", wr_en, grant_id, wr_data);
        end
        next_cycle();
        req_valid = 4'b0011;
        @(negedge clk);
        tests_run++;
        if (wr_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL wd_drop: wr_en=%b busy=%b id=%0d want 0/1/3", wr_en, busy, grant_id);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL wd_bubble: busy=%b wr_en=%b id=%0d want 0/0/0", busy, wr_en, grant_id);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || wr_en !== 1'b1 || wr_data !== 8'h40) begin
            tests_failed++;
            $display("FAIL wd_regrant: busy=%b id=%0d wr_en=%b data=%h want 1/0/1/40", busy, grant_id, wr_en, wr_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        bit exp_wr [5];
        bit exp_busy [5];
        bit exp_rst [5];
        int b = 0;
        logic acc;
        exp_wr   = '{0, 1, 0, 0, 1};
        exp_busy = '{0, 1, 0, 0, 1};
        exp_rst  = '{0, 0, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            rst       = exp_rst[c];
            req_valid = 4'b1100;
            req_last  = '0;
            req_data  = {8'h60, 8'(8'h50 + b), 16'h0000};
            @(negedge clk);
            tests_run++;
            if (wr_en !== exp_wr[c] || busy !== exp_busy[c]) begin
                tests_failed++;
                $display("FAIL rstmid_ctrl cycle %0d: wr_en=%b busy=%b want %b/%b", c, wr_en, busy, exp_wr[c], exp_busy[c]);
            end
            if (exp_wr[c]) begin
                tests_run++;
                if (grant_id !== 2'd2 || wr_data !== 8'(8'h50 + c / 4)) begin
                    tests_failed++;
                    $display("FAIL rstmid_data cycle %0d: id=%0d data=%h want 2/%h", c, grant_id, wr_data, 8'(8'h50 + c / 4));
                end
            end
            acc = req_ready[2];
            next_cycle();
            if (acc) b++;
        end
        rst = 1'b0;
    endtask

    task automatic test_random_scoreboard();
        int   seq [NR];
        bit   pend [NR];
        logic [NR-1:0] acc;
        logic [DW-1:0] exp;
        int   g;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0; pend[i] = 1'b0; exp_q[i].delete();
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            full = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            tests_run++;
            if (wr_en && full) begin
                tests_failed++;
                $display("FAIL sb_write_while_full cycle %0d: wr_en=1 full=1", cyc);
            end
            if (wr_en) begin
                g = int'(grant_id);
                tests_run++;
                if (exp_q[g].size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_data cycle %0d: write %h from %0d with nothing expected", cyc, wr_data, g);
                end else begin
                    exp = exp_q[g].pop_front();
                    if (wr_data !== exp || req_ready !== 4'(1 << g)) begin
                        tests_failed++;
                        $display("FAIL sb_data cycle %0d: data=%h ready=%b want %h/%b", cyc, wr_data, req_ready, exp, 4'(1 << g));
                    end
                end
            end else begin
                tests_run++;
                if (req_ready !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL sb_ready cycle %0d: ready=%b without wr_en", cyc, req_ready);
                end
            end
            acc = req_ready;
            next_cycle();
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    pend[i] = 1'b0;
                    seq[i]++;
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    if (!pend[i]) begin
                        pend[i] = 1'b1;
                        req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
                        req_last[i] = ($urandom_range(0, 2) == 0);
                        exp_q[i].push_back({2'(i), 6'(seq[i])});
                    end
                    req_valid[i] = 1'b1;
                end
            end
        end
        full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_full_stall();
        test_withdrawal();
        test_reset_mid_burst();
        test_random_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
